n_b2_serial_comparator: RTL and testbench

- Parametrised, multi-cycle successor to the 4-bit base-2 comparator.
- Compares two N-bit operands K bits per clock, LSB slice first, with a registered borrow chain through one K-bit subtractor slice.
- Produces eq/gr/lr flags for unsigned or two's-complement operands, selected per operation.
- Used where wide comparisons must be cheap in area; handshake is start/ready/done.

---
 rtl/n_b2_serial_comparator_pkg.sv | 33 +++
 rtl/n_b2_serial_comparator_if.sv | 28 ++
 rtl/n_b2_serial_comparator_subtractor_slice.sv | 29 ++
 rtl/n_b2_serial_comparator.sv | 111 +++++++++++
 tb/tb_n_b2_serial_comparator.sv | 134 +++++++++++++
 5 files changed

// File: rtl/n_b2_serial_comparator_pkg.sv
// Shared definitions for the serial N-bit base-2 comparator.
// Contents:
//   S_IDLE, S_RUN  - controller state encoding
//   clog2()        - ceiling log2, usable in constant expressions
//   cnt_width()    - slice counter width: clog2(steps), at least 1 bit
//   steps_of()     - number of K-bit slice cycles for an N-bit compare
package n_b2_serial_comparator_pkg;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int steps_of(input int n, input int k);
        return n / k;
    endfunction

    // A one-step compare still needs a 1-bit counter to keep the
    // declared vector legal.
    function automatic int cnt_width(input int steps);
        return (clog2(steps) < 1) ? 1 : clog2(steps);
    endfunction

endpackage

// File: rtl/n_b2_serial_comparator_if.sv
// Request/response bundle of the serial comparator.
// Signals:
//   start, signed_mode, x, y           - request, driven by the master
//   ready, done, flag_eq/gr/lr         - status and result, driven by the slave
// Modports: master (requester side), slave (comparator side).
interface n_b2_serial_comparator_if #(
    parameter int N = 16
);
    logic         start;
    logic         signed_mode;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         ready;
    logic         done;
    logic         flag_eq;
    logic         flag_gr;
    logic         flag_lr;

    modport master (
        output start, signed_mode, x, y,
        input  ready, done, flag_eq, flag_gr, flag_lr
    );

    modport slave (
        input  start, signed_mode, x, y,
        output ready, done, flag_eq, flag_gr, flag_lr
    );
endinterface

// File: rtl/n_b2_serial_comparator_subtractor_slice.sv
// K-bit combinational ripple-borrow subtractor: dk = xk - yk - bin.
// Ports:
//   xk, yk - K-bit minuend / subtrahend slice
//   bin    - borrow in from the previous (less significant) slice
//   dk     - K-bit difference
//   bout   - borrow out of the most significant bit
module nk_b2_subtractor_slice #(
    parameter int K = 4
) (
    input  logic [K-1:0] xk,
    input  logic [K-1:0] yk,
    input  logic         bin,
    output logic [K-1:0] dk,
    output logic         bout
);
    logic [K:0] b;

    assign b[0] = bin;

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_bit
            assign dk[gi]  = xk[gi] ^ yk[gi] ^ b[gi];
            // Borrow when x<y at this bit, or x==y and a borrow arrives.
            assign b[gi+1] = (~xk[gi] & yk[gi]) | (~(xk[gi] ^ yk[gi]) & b[gi]);
        end
    endgenerate

    assign bout = b[K];
endmodule

// File: rtl/n_b2_serial_comparator.sv
// Serial N-bit comparator: processes K bits per clock, LSB slice first,
// through a single K-bit subtractor slice with a registered borrow.
// Produces one-hot eq/gr/lr flags for unsigned or two's-complement operands.
// Ports:
//   clock - system clock (rising edge)
//   reset - synchronous active-high reset
//   bus   - slave side of n_b2_serial_comparator_if (start/ready/done,
//           operands, signed_mode, result flags)
module n_b2_serial_comparator
    import n_b2_serial_comparator_pkg::*;
#(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    n_b2_serial_comparator_if.slave  bus
);
    localparam int STEPS = steps_of(N, K);
    localparam int CW    = cnt_width(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    logic [0:0]   state_reg;
    logic [CW-1:0] cnt_reg;
    logic         borrow_reg;
    logic         zacc_reg;
    logic         signed_reg;
    logic         xm_reg;
    logic         ym_reg;
    logic [N-1:0] x_reg;
    logic [N-1:0] y_reg;
    logic         done_reg;
    logic         eq_reg;
    logic         gr_reg;
    logic         lr_reg;

    logic [K-1:0] dk;
    logic         bout;
    logic         zacc_next;
    logic         lt_next;

    // Operand registers shift right by K each step, so the current slice
    // always sits in the low K bits.
    nk_b2_subtractor_slice #(.K(K)) u_slice (
        .xk   (x_reg[K-1:0]),
        .yk   (y_reg[K-1:0]),
        .bin  (borrow_reg),
        .dk   (dk),
        .bout (bout)
    );

    assign zacc_next = zacc_reg & (dk == '0);
    // Signed compare: the final borrow is the unsigned result; differing
    // sign bits invert it.
    assign lt_next   = signed_reg ? (bout ^ xm_reg ^ ym_reg) : bout;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
            zacc_reg   <= 1'b1;
            signed_reg <= 1'b0;
            xm_reg     <= 1'b0;
            ym_reg     <= 1'b0;
            x_reg      <= '0;
            y_reg      <= '0;
            done_reg   <= 1'b0;
            eq_reg     <= 1'b0;
            gr_reg     <= 1'b0;
            lr_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        x_reg      <= bus.x;
                        y_reg      <= bus.y;
                        xm_reg     <= bus.x[N-1];
                        ym_reg     <= bus.y[N-1];
                        signed_reg <= bus.signed_mode;
                        borrow_reg <= 1'b0;
                        zacc_reg   <= 1'b1;
                        cnt_reg    <= '0;
                        state_reg  <= S_RUN;
                    end
                end
                default: begin
                    borrow_reg <= bout;
                    zacc_reg   <= zacc_next;
                    cnt_reg    <= cnt_reg + CW'(1);
                    x_reg      <= x_reg >> K;
                    y_reg      <= y_reg >> K;
                    if (cnt_reg == LAST) begin
                        eq_reg    <= zacc_next;
                        gr_reg    <= ~lt_next & ~zacc_next;
                        lr_reg    <= lt_next & ~zacc_next;
                        done_reg  <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.ready   = (state_reg == S_IDLE);
    assign bus.done    = done_reg;
    assign bus.flag_eq = eq_reg;
    assign bus.flag_gr = gr_reg;
    assign bus.flag_lr = lr_reg;
endmodule

// File: tb/tb_n_b2_serial_comparator.sv
// Directed bench for n_b2_serial_comparator (N=16, K=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_n_b2_serial_comparator;
    localparam int N = 16;
    localparam int K = 4;
    localparam int STEPS = N / K;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    n_b2_serial_comparator_if #(.N(N)) bus ();

    n_b2_serial_comparator #(.N(N), .K(K)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: presents a request for one rising edge.
    task automatic launch(input logic [N-1:0] xv, input logic [N-1:0] yv, input logic sm);
        bus.start       = 1'b1;
        bus.x           = xv;
        bus.y           = yv;
        bus.signed_mode = sm;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for done, then checks latency and flags {eq,gr,lr}.
    task automatic wait_done(input string tag, input logic [2:0] exp_flags);
        int cycles;
        cycles = 0;
        while (!bus.done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check_val({tag, " latency"}, cycles, STEPS);
        check_val({tag, " flags"}, {bus.flag_eq, bus.flag_gr, bus.flag_lr}, exp_flags);
        check_val({tag, " ready@done"}, bus.ready, 1'b1);
        $display("cmp %s: x=%h y=%h cycles=%0d flags(eq,gr,lr)=%b", tag, bus.x, bus.y,
                 cycles, {bus.flag_eq, bus.flag_gr, bus.flag_lr});
    endtask

    task automatic do_cmp(input string tag, input logic [N-1:0] xv, input logic [N-1:0] yv,
                          input logic sm, input logic [2:0] exp_flags);
        @(negedge clk);
        launch(xv, yv, sm);
        wait_done(tag, exp_flags);
    endtask

    initial begin
        int dones;
        n_checks        = 0;
        n_pass          = 0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.x           = '0;
        bus.y           = '0;
        repeat (3) @(negedge clk);
        check_val("reset ready", bus.ready, 1'b1);
        check_val("reset done", bus.done, 1'b0);
        check_val("reset flags", {bus.flag_eq, bus.flag_gr, bus.flag_lr}, 3'b000);
        rst = 1'b0;

        do_cmp("u_eq",        16'h1234, 16'h1234, 1'b0, 3'b100);
        do_cmp("u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 3'b010);
        do_cmp("s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 3'b001);
        do_cmp("u_0_ffff",    16'h0000, 16'hFFFF, 1'b0, 3'b001);
        do_cmp("s_0_ffff",    16'h0000, 16'hFFFF, 1'b1, 3'b010);
        do_cmp("s_eq_neg",    16'hFFF0, 16'hFFF0, 1'b1, 3'b100);

        // Start during RUN and operand changes must be ignored.
        @(negedge clk);
        launch(16'd5, 16'd9, 1'b0);
        dones = 0;
        for (int c = 0; c < STEPS; c++) begin
            check_val($sformatf("run ready c%0d", c), bus.ready, 1'b0);
            bus.start = (c < STEPS - 1);
            bus.x     = 16'd9;
            bus.y     = 16'd5;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check_val("ignore done", bus.done, 1'b1);
        check_val("ignore flags", {bus.flag_eq, bus.flag_gr, bus.flag_lr}, 3'b001);
        $display("cmp ignore: x=5 y=9 with stray start, flags(eq,gr,lr)=%b",
                 {bus.flag_eq, bus.flag_gr, bus.flag_lr});
        for (int c = 0; c < 8; c++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        check_val("ignore single done", dones, 1);

        // Reset in the second RUN cycle aborts without a done pulse.
        launch(16'h00FF, 16'h0100, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort ready", bus.ready, 1'b1);
        check_val("abort flags", {bus.flag_eq, bus.flag_gr, bus.flag_lr}, 3'b000);
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        check_val("abort no done", dones, 0);
        $display("cmp abort: reset mid-run, dones=%0d", dones);
        do_cmp("after_abort_eq", 16'h0000, 16'h0000, 1'b0, 3'b100);

        // Back-to-back: second start issued in the done cycle of the first.
        do_cmp("b2b_first", 16'd2, 16'd3, 1'b0, 3'b001);
        launch(16'd3, 16'd2, 1'b0);
        wait_done("b2b_second", 3'b010);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
